// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter.
// Optional debug read port: MEM_ARB_DBG_EN.
package mem_arb_pkg;

  // Owner of the access granted in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  // Legal range of the fetch starvation threshold and its counter width.
  localparam int unsigned STARVE_MAX_MIN = 1;
  localparam int unsigned STARVE_MAX_LIM = 15;
  localparam int unsigned STARVE_CNT_W   = 4;

  // Pull an out-of-range threshold back into the legal range.
  function automatic int unsigned starve_clamp(int unsigned v);
    if (v < STARVE_MAX_MIN) begin
      return STARVE_MAX_MIN;
    end else if (v > STARVE_MAX_LIM) begin
      return STARVE_MAX_LIM;
    end
    return v;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline, the arbiter and the RAM.
// Debug read signals exist only when MEM_ARB_DBG_EN is defined.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  // Load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

`ifdef MEM_ARB_DBG_EN
  // Debug read port
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_rdata;
`endif

  // RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_ARB_DBG_EN
  // Requesters plus RAM model
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, dbg_req, dbg_addr, ram_rdata,
    input  if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
    input  dbg_gnt, dbg_valid, dbg_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Arbiter
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, dbg_req, dbg_addr, ram_rdata,
    output if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
    output dbg_gnt, dbg_valid, dbg_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
`else
  // Requesters plus RAM model
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  // Arbiter
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
`endif

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant picker: M > IF > DBG, except a starved fetch beats M once.
// Debug request/grant exist only when MEM_ARB_DBG_EN is defined.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_DBG_EN
  input  logic dbg_req,
  output logic dbg_gnt,
`endif
  input  logic starve_hit,
  output logic if_gnt,
  output logic d_gnt
);

  // One-hot grant selection; starve_hit already implies if_req.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
`ifdef MEM_ARB_DBG_EN
    dbg_gnt = 1'b0;
`endif
    if (starve_hit) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
`ifdef MEM_ARB_DBG_EN
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch, load/store and (optionally) a
// debug reader. One access per cycle, read data one cycle after grant.
// Define MEM_ARB_DBG_EN to add the debug read port (lowest priority, no starvation guard).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_W-1:0] StarveLim = STARVE_CNT_W'(starve_clamp(STARVE_MAX));

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_e                  owner_q, owner_d;

  logic if_req_g, d_req_g;
  logic if_gnt, d_gnt;
  logic starve_hit;
`ifdef MEM_ARB_DBG_EN
  logic dbg_req_g, dbg_gnt;
`endif

  // Requests are masked during reset so nothing is granted or stalled.
  always_comb begin
    if_req_g   = rst_n & bus.if_req;
    d_req_g    = rst_n & bus.d_req;
`ifdef MEM_ARB_DBG_EN
    dbg_req_g  = rst_n & bus.dbg_req;
`endif
    starve_hit = if_req_g & (starve_cnt_q == StarveLim);
  end

  mem_arb_pick u_pick (
    .if_req     (if_req_g),
    .d_req      (d_req_g),
`ifdef MEM_ARB_DBG_EN
    .dbg_req    (dbg_req_g),
    .dbg_gnt    (dbg_gnt),
`endif
    .starve_hit (starve_hit),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt)
  );

  // Starvation count and next owner.
  always_comb begin
    starve_cnt_d = '0;
    if (if_req_g && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == StarveLim) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt) begin
      owner_d = OWN_D;
`ifdef MEM_ARB_DBG_EN
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  // Requester-side outputs; valids are held low while in reset.
  always_comb begin
    bus.if_gnt   = if_gnt;
    bus.if_stall = if_req_g & ~if_gnt;
    bus.if_valid = rst_n & (owner_q == OWN_IF);
    bus.if_rdata = bus.ram_rdata;
    bus.d_gnt    = d_gnt;
    bus.d_stall  = d_req_g & ~d_gnt;
    bus.d_valid  = rst_n & (owner_q == OWN_D);
    bus.d_rdata  = bus.ram_rdata;
`ifdef MEM_ARB_DBG_EN
    bus.dbg_gnt   = dbg_gnt;
    bus.dbg_valid = rst_n & (owner_q == OWN_DBG);
    bus.dbg_rdata = bus.ram_rdata;
`endif
  end

  // RAM drive muxed from the granted port; only a store grant writes.
  always_comb begin
    bus.ram_wdata = bus.d_wdata;
    bus.ram_we    = d_gnt & bus.d_we;
`ifdef MEM_ARB_DBG_EN
    bus.ram_en    = if_gnt | d_gnt | dbg_gnt;
    bus.ram_addr  = d_gnt ? bus.d_addr : (if_gnt ? bus.if_addr : bus.dbg_addr);
`else
    bus.ram_en    = if_gnt | d_gnt;
    bus.ram_addr  = d_gnt ? bus.d_addr : bus.if_addr;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and scoreboard queues.
// Debug-port scenario runs only when MEM_ARB_DBG_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port RAM, 1-cycle read latency.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= ram[bus.ram_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          chk_data;
    logic [DW-1:0] data;
  } exp_t;

  exp_t   q_if[$];
  exp_t   q_d[$];
  exp_t   q_dbg[$];
  int     m_starve = 0;
  owner_e m_owner  = OWN_NONE;

  // Values observed at the most recent sampling point.
  logic          last_if_gnt, last_d_gnt, last_if_valid, last_d_valid;
  logic [DW-1:0] last_if_rdata, last_d_rdata;
`ifdef MEM_ARB_DBG_EN
  logic          last_dbg_gnt, last_dbg_valid;
  logic [DW-1:0] last_dbg_rdata;
`endif

  // One clock: check outputs against the model at negedge, update model, advance.
  task automatic cycle();
    bit   e_if, e_d, e_dbg;
    exp_t e;
    @(negedge clk);
    e_if  = 1'b0;
    e_d   = 1'b0;
    e_dbg = 1'b0;
    if (rst_n) begin
      if (bus.if_req && m_starve == SMAX) e_if = 1'b1;
      else if (bus.d_req)                 e_d  = 1'b1;
      else if (bus.if_req)                e_if = 1'b1;
`ifdef MEM_ARB_DBG_EN
      if (!e_if && !e_d && bus.dbg_req) e_dbg = 1'b1;
`endif
    end
    check("if_gnt", bus.if_gnt, e_if);
    check("d_gnt", bus.d_gnt, e_d);
    check("if_stall", bus.if_stall, rst_n & bus.if_req & !e_if);
    check("d_stall", bus.d_stall, rst_n & bus.d_req & !e_d);
    check("ram_en", bus.ram_en, e_if | e_d | e_dbg);
    check("ram_we", bus.ram_we, e_d & bus.d_we);
    if (e_d) begin
      check("ram_addr_d", bus.ram_addr, bus.d_addr);
      if (bus.d_we) check("ram_wdata", bus.ram_wdata, bus.d_wdata);
    end else if (e_if) begin
      check("ram_addr_if", bus.ram_addr, bus.if_addr);
    end
`ifdef MEM_ARB_DBG_EN
    check("dbg_gnt", bus.dbg_gnt, e_dbg);
    if (e_dbg) check("ram_addr_dbg", bus.ram_addr, bus.dbg_addr);
    check("dbg_valid", bus.dbg_valid, rst_n && m_owner == OWN_DBG);
    if (rst_n && m_owner == OWN_DBG) begin
      e = q_dbg.pop_front();
      check("dbg_rdata", bus.dbg_rdata, e.data);
    end
    last_dbg_gnt   = bus.dbg_gnt;
    last_dbg_valid = bus.dbg_valid;
    last_dbg_rdata = bus.dbg_rdata;
`endif
    check("if_valid", bus.if_valid, rst_n && m_owner == OWN_IF);
    check("d_valid", bus.d_valid, rst_n && m_owner == OWN_D);
    if (rst_n && m_owner == OWN_IF) begin
      e = q_if.pop_front();
      check("if_rdata", bus.if_rdata, e.data);
    end
    if (rst_n && m_owner == OWN_D) begin
      e = q_d.pop_front();
      if (e.chk_data) check("d_rdata", bus.d_rdata, e.data);
    end
    if (!rst_n) begin
      q_if.delete();
      q_d.delete();
      q_dbg.delete();
    end
    last_if_gnt   = bus.if_gnt;
    last_d_gnt    = bus.d_gnt;
    last_if_valid = bus.if_valid;
    last_d_valid  = bus.d_valid;
    last_if_rdata = bus.if_rdata;
    last_d_rdata  = bus.d_rdata;
    // Push expectations for accesses granted this cycle.
    if (e_if) q_if.push_back('{1'b1, ref_mem[bus.if_addr]});
    if (e_d) begin
      if (bus.d_we) begin
        q_d.push_back('{1'b0, '0});
        ref_mem[bus.d_addr] = bus.d_wdata;
      end else begin
        q_d.push_back('{1'b1, ref_mem[bus.d_addr]});
      end
    end
`ifdef MEM_ARB_DBG_EN
    if (e_dbg) q_dbg.push_back('{1'b1, ref_mem[bus.dbg_addr]});
`endif
    if (!rst_n)      m_owner = OWN_NONE;
    else if (e_if)   m_owner = OWN_IF;
    else if (e_d)    m_owner = OWN_D;
    else if (e_dbg)  m_owner = OWN_DBG;
    else             m_owner = OWN_NONE;
    if (!rst_n)                     m_starve = 0;
    else if (bus.if_req && !e_if)   m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
    else                            m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = ram[i];
    end
    ram[10'h010] = 32'h2008_0005;  ref_mem[10'h010] = 32'h2008_0005;
    ram[10'h011] = 32'h1111_0011;  ref_mem[10'h011] = 32'h1111_0011;

    // Reset with both requests asserted.
    rst_n       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h020;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 10'h030;
    bus.d_wdata = '0;
`ifdef MEM_ARB_DBG_EN
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;
`endif
    repeat (3) begin
      cycle();
      check("rst_gnt", last_if_gnt | last_d_gnt, 1'b0);
      check("rst_valid", last_if_valid | last_d_valid, 1'b0);
    end
    rst_n = 1'b1;
    cycle();
    cycle();
    check("rel_first_valid", last_d_valid, 1'b1);
    idle();
    cycle();
    cycle();

    // Single fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h010;
    cycle();
    check("fetch_gnt", last_if_gnt, 1'b1);
    bus.if_req = 1'b0;
    cycle();
    check("fetch_valid", last_if_valid, 1'b1);
    check("fetch_rdata", last_if_rdata, 32'h2008_0005);

    // Contention: D,D,D,IF repeating.
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h020;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 10'h030;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("cont_if_gnt", last_if_gnt, (k % 4) == 3);
      check("cont_d_gnt", last_d_gnt, (k % 4) != 3);
    end
    idle();
    cycle();

    // Store then load at the same address.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h004;
    bus.d_wdata = 32'hDEAD_BEEF;
    cycle();
    bus.d_we = 1'b0;
    cycle();
    check("st_valid", last_d_valid, 1'b1);
    idle();
    cycle();
    check("ld_valid", last_d_valid, 1'b1);
    check("ld_rdata", last_d_rdata, 32'hDEAD_BEEF);

    // Same-address fetch and store: store first, fetch sees new data.
    bus.if_req  = 1'b1;
    bus.if_addr = 10'h008;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 10'h008;
    bus.d_wdata = 32'hCAFE_0008;
    cycle();
    check("same_d_first", last_d_gnt, 1'b1);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    cycle();
    check("same_if_second", last_if_gnt, 1'b1);
    bus.if_req = 1'b0;
    cycle();
    check("same_if_new", last_if_rdata, 32'hCAFE_0008);

    // Reset in the middle of contention after starvation has built up.
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 10'h030;
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_mid_dgnt", last_d_gnt, 1'b0);
    rst_n = 1'b1;
    idle();
    cycle();
    check("rst_mid_no_valid", last_d_valid, 1'b0);
    check("rst_mid_starve", dut.starve_cnt_q, '0);
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("post_rst_if_gnt", last_if_gnt, k == 3);
    end
    idle();
    cycle();

`ifdef MEM_ARB_DBG_EN
    // Debug waits for the first cycle with no IF/M request.
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 10'h011;
    bus.if_req   = 1'b1;
    bus.if_addr  = 10'h012;
    repeat (5) begin
      cycle();
      check("dbg_blocked", last_dbg_gnt, 1'b0);
    end
    bus.if_req = 1'b0;
    cycle();
    check("dbg_idle_gnt", last_dbg_gnt, 1'b1);
    bus.dbg_req = 1'b0;
    cycle();
    check("dbg_valid_next", last_dbg_valid, 1'b1);
    check("dbg_word", last_dbg_rdata, 32'h1111_0011);
`endif

    // Random traffic over a small address window with occasional resets.
    for (int n = 0; n < 300; n++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      bus.if_req  = $urandom_range(0, 1);
      bus.if_addr = 10'($urandom_range(0, 15));
      bus.d_req   = $urandom_range(0, 1);
      bus.d_we    = $urandom_range(0, 1);
      bus.d_addr  = 10'($urandom_range(0, 15));
      bus.d_wdata = $urandom;
`ifdef MEM_ARB_DBG_EN
      bus.dbg_req  = $urandom_range(0, 1);
      bus.dbg_addr = 10'($urandom_range(0, 15));
`endif
      cycle();
    end
    rst_n = 1'b1;
    idle();
`ifdef MEM_ARB_DBG_EN
    bus.dbg_req = 1'b0;
`endif
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
